// File: rtl/round_choice_encoder.sv
// round_choice_encoder: collects both players' button actions during a timed window,
// locks them, applies ammo rules and presents stable one-hot choices.
module round_choice_encoder #(
    parameter int ROUND_CYCLES = 300_000_000,
    parameter int CNT_W        = 29,
    parameter int MAX_AMMO     = 3,
    parameter int INIT_AMMO    = 1,
    parameter int AMMO_W       = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_round,
    input  logic [2:0]        p1_btn,
    input  logic [2:0]        p2_btn,
    output logic [3:0]        p1_choice,
    output logic [3:0]        p2_choice,
    output logic              choices_valid,
    output logic              round_active,
    output logic [CNT_W-1:0]  time_left,
    output logic              p1_locked,
    output logic              p2_locked,
    output logic [AMMO_W-1:0] p1_ammo,
    output logic [AMMO_W-1:0] p2_ammo
);

    typedef enum logic [1:0] {IDLE, COLLECT, PRESENT} state_t;
    typedef enum logic [1:0] {ACT_NONE, ACT_RELOAD, ACT_SHOOT, ACT_BLOCK} act_t;

    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(ROUND_CYCLES - 1);
    localparam logic [AMMO_W-1:0] AMMO_MAX  = AMMO_W'(MAX_AMMO);
    localparam logic [AMMO_W-1:0] AMMO_INIT = AMMO_W'(INIT_AMMO);

    localparam logic [3:0] CH_RELOAD = 4'b1000;
    localparam logic [3:0] CH_SHOOT  = 4'b0100;
    localparam logic [3:0] CH_IDLE   = 4'b0010;
    localparam logic [3:0] CH_BLOCK  = 4'b0001;

    state_t state;
    act_t   p1_act, p2_act;
    act_t   p1_act_nxt, p2_act_nxt;
    logic   round_done;
    logic [3:0]        p1_choice_nxt, p2_choice_nxt;
    logic [AMMO_W-1:0] p1_ammo_nxt, p2_ammo_nxt;

    // Simultaneous presses resolve as shoot > block > reload.
    function automatic act_t decode_btn(input logic [2:0] btn);
        return btn[1] ? ACT_SHOOT : btn[0] ? ACT_BLOCK : btn[2] ? ACT_RELOAD : ACT_NONE;
    endfunction

    // A shot with an empty magazine degrades to idle.
    function automatic logic [3:0] encode_choice(input act_t act, input logic [AMMO_W-1:0] ammo);
        return act == ACT_RELOAD ? CH_RELOAD :
               act == ACT_BLOCK  ? CH_BLOCK  :
               (act == ACT_SHOOT && ammo != '0) ? CH_SHOOT : CH_IDLE;
    endfunction

    function automatic logic [AMMO_W-1:0] update_ammo(input act_t act, input logic [AMMO_W-1:0] ammo);
        return (act == ACT_SHOOT && ammo != '0) ? ammo - AMMO_W'(1) :
               (act == ACT_RELOAD && ammo != AMMO_MAX) ? ammo + AMMO_W'(1) : ammo;
    endfunction

    // Resolve this edge's actions (a press on the closing edge still counts) and their effects.
    always_comb begin
        p1_act_nxt    = (!p1_locked && |p1_btn) ? decode_btn(p1_btn) : p1_act;
        p2_act_nxt    = (!p2_locked && |p2_btn) ? decode_btn(p2_btn) : p2_act;
        round_done    = (p1_locked && p2_locked) || time_left == '0;
        p1_choice_nxt = encode_choice(p1_act_nxt, p1_ammo);
        p2_choice_nxt = encode_choice(p2_act_nxt, p2_ammo);
        p1_ammo_nxt   = update_ammo(p1_act_nxt, p1_ammo);
        p2_ammo_nxt   = update_ammo(p2_act_nxt, p2_ammo);
    end

    // Round FSM with all outputs registered; ammo only moves on the COLLECT->PRESENT edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            p1_act        <= ACT_NONE;
            p2_act        <= ACT_NONE;
            p1_choice     <= '0;
            p2_choice     <= '0;
            choices_valid <= 1'b0;
            round_active  <= 1'b0;
            time_left     <= '0;
            p1_locked     <= 1'b0;
            p2_locked     <= 1'b0;
            p1_ammo       <= AMMO_INIT;
            p2_ammo       <= AMMO_INIT;
        end else begin
            case (state)
                COLLECT: begin
                    p1_act    <= p1_act_nxt;
                    p2_act    <= p2_act_nxt;
                    p1_locked <= p1_locked | (|p1_btn);
                    p2_locked <= p2_locked | (|p2_btn);
                    time_left <= time_left == '0 ? '0 : time_left - CNT_W'(1);
                    if (round_done) begin
                        state         <= PRESENT;
                        p1_choice     <= p1_choice_nxt;
                        p2_choice     <= p2_choice_nxt;
                        p1_ammo       <= p1_ammo_nxt;
                        p2_ammo       <= p2_ammo_nxt;
                        choices_valid <= 1'b1;
                        round_active  <= 1'b0;
                    end
                end
                default: begin
                    if (start_round) begin
                        state         <= COLLECT;
                        p1_act        <= ACT_NONE;
                        p2_act        <= ACT_NONE;
                        p1_choice     <= '0;
                        p2_choice     <= '0;
                        choices_valid <= 1'b0;
                        round_active  <= 1'b1;
                        time_left     <= CNT_LOAD;
                        p1_locked     <= 1'b0;
                        p2_locked     <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_choice_encoder.sv
// tb_round_choice_encoder: directed vectors with hand-computed expectations.
module tb_round_choice_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_round = 1'b0;
    logic [2:0] p1_btn = 3'b000;
    logic [2:0] p2_btn = 3'b000;
    logic [3:0] p1_choice, p2_choice;
    logic       choices_valid, round_active, p1_locked, p2_locked;
    logic [3:0] time_left;
    logic [1:0] p1_ammo, p2_ammo;

    int checks = 0;
    int failures = 0;

    round_choice_encoder #(
        .ROUND_CYCLES(8), .CNT_W(4), .MAX_AMMO(3), .INIT_AMMO(1), .AMMO_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_round(start_round),
        .p1_btn(p1_btn), .p2_btn(p2_btn),
        .p1_choice(p1_choice), .p2_choice(p2_choice),
        .choices_valid(choices_valid), .round_active(round_active),
        .time_left(time_left), .p1_locked(p1_locked), .p2_locked(p2_locked),
        .p1_ammo(p1_ammo), .p2_ammo(p2_ammo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    // Start a round, press both buttons on the first collect cycle, wait for the result.
    task automatic run_round(input logic [2:0] b1, input logic [2:0] b2);
        start_round = 1'b1;
        tick();
        start_round = 1'b0;
        p1_btn = b1;
        p2_btn = b2;
        tick();
        p1_btn = 3'b000;
        p2_btn = 3'b000;
        for (int i = 0; i < 20 && !choices_valid; i++) tick();
        check("round_timeout", {31'd0, choices_valid}, 32'd1);
    endtask

    initial begin
        tick();
        tick();
        check("rst_p1_choice", p1_choice, 4'b0000);
        check("rst_valid", choices_valid, 1'b0);
        check("rst_active", round_active, 1'b0);
        check("rst_ammo", {p1_ammo, p2_ammo}, 4'b0101);
        rst_n = 1'b1;
        tick();

        // Test 1: stale start ignored, then async reset mid-COLLECT
        start_round = 1'b1;
        tick();
        check("t1_load", time_left, 4'd7);
        tick();
        check("t1_stale_start", time_left, 4'd6);
        start_round = 1'b0;
        tick();
        check("t1_tl5", time_left, 4'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_async_tl", time_left, 4'd0);
        check("t1_async_active", round_active, 1'b0);
        check("t1_async_choice", {p1_choice, p2_choice}, 8'h00);
        check("t1_async_valid", choices_valid, 1'b0);
        check("t1_async_ammo", {p1_ammo, p2_ammo}, 4'b0101);
        #2;
        rst_n = 1'b1;
        tick();
        check("t1_idle", round_active, 1'b0);

        // Test 2: p1 shoot at cycle 2, p2 reload at cycle 3
        start_round = 1'b1;
        tick();
        start_round = 1'b0;
        tick();
        p1_btn = 3'b010;
        tick();
        p1_btn = 3'b000;
        check("t2_p1_locked", {p1_locked, p2_locked}, 2'b10);
        p2_btn = 3'b100;
        tick();
        p2_btn = 3'b000;
        check("t2_not_yet", {choices_valid, round_active}, 2'b01);
        tick();
        check("t2_p1_choice", p1_choice, 4'b0100);
        check("t2_p2_choice", p2_choice, 4'b1000);
        check("t2_valid", {choices_valid, round_active}, 2'b10);
        check("t2_ammo", {p1_ammo, p2_ammo}, 4'b0010);
        tick();
        tick();
        check("t2_hold", {choices_valid, p1_choice, p2_choice, p1_ammo, p2_ammo}, {1'b1, 8'b01001000, 4'b0010});

        // Test 3: timeout with no presses
        start_round = 1'b1;
        tick();
        start_round = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("t3_edge7", {choices_valid, round_active}, 2'b01);
        check("t3_tl0", time_left, 4'd0);
        tick();
        check("t3_edge8", {choices_valid, round_active}, 2'b10);
        check("t3_choices", {p1_choice, p2_choice}, 8'b00100010);
        check("t3_ammo", {p1_ammo, p2_ammo}, 4'b0010);

        // Test 4: empty-magazine shot degrades to idle
        run_round(3'b010, 3'b001);
        check("t4_choices", {p1_choice, p2_choice}, 8'b00100001);
        check("t4_ammo", {p1_ammo, p2_ammo}, 4'b0010);

        // Test 5a: shoot priority, later press ignored
        do_reset();
        start_round = 1'b1;
        tick();
        start_round = 1'b0;
        p1_btn = 3'b111;
        tick();
        p1_btn = 3'b100;
        tick();
        p1_btn = 3'b000;
        p2_btn = 3'b100;
        tick();
        p2_btn = 3'b000;
        tick();
        check("t5_prio", {choices_valid, p1_choice, p2_choice}, {1'b1, 8'b01001000});
        check("t5_prio_ammo", {p1_ammo, p2_ammo}, 4'b0010);

        // Test 5b: reload saturation
        do_reset();
        for (int r = 0; r < 4; r++) begin
            run_round(3'b100, 3'b100);
            check("t5_reload_choice", {p1_choice, p2_choice}, 8'b10001000);
            check("t5_reload_ammo", {p1_ammo, p2_ammo}, (r == 0) ? 4'b1010 : 4'b1111);
        end

        // Test 6: lone press on the final collect cycle, then restart from PRESENT
        start_round = 1'b1;
        tick();
        start_round = 1'b0;
        for (int i = 0; i < 20 && time_left != 4'd0; i++) tick();
        check("t6_tl0", {time_left, choices_valid}, 5'b00000);
        p2_btn = 3'b001;
        tick();
        p2_btn = 3'b000;
        check("t6_valid", choices_valid, 1'b1);
        check("t6_choices", {p1_choice, p2_choice}, 8'b00100001);
        check("t6_ammo", {p1_ammo, p2_ammo}, 4'b1111);
        start_round = 1'b1;
        tick();
        start_round = 1'b0;
        check("t6_restart", {p1_choice, p2_choice, choices_valid, round_active}, 10'b0000000001);
        check("t6_restart_tl", time_left, 4'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/round_choice_encoder.md
Name: round_choice_encoder

Overview:
- Front end of the standoff round: collects each player's button action during a timed window and encodes it into the one-hot choice words consumed by the outcome calculator.
- Locks both choices when the timer expires or both players have committed, then presents them stable.
- Tracks per-player ammo, so a shot without ammo is downgraded.
- Sits between the debounced button/synchroniser logic and the outcome calculator.

Parameters:
- ROUND_CYCLES, 300_000_000: length of the collect window in clk cycles (3 s at 100 MHz); must be >= 2.
- CNT_W, 29: width of the countdown; must satisfy 2^CNT_W > ROUND_CYCLES.
- MAX_AMMO, 3: ammo saturation value.
- INIT_AMMO, 1: ammo loaded at reset; must be <= MAX_AMMO.
- AMMO_W, 2: ammo counter width; must satisfy 2^AMMO_W > MAX_AMMO.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- rst_n, input, 1: asynchronous, active-low reset.
- start_round, input, 1: single-cycle pulse that begins a round.
- p1_btn, input, 3: {reload, shoot, block}; debounced, synchronised, single-cycle pulses.
- p2_btn, input, 3: same format as p1_btn, for player 2.
- p1_choice, output, 4: one-hot choice. 1000 = reload, 0100 = shoot, 0010 = idle/no action, 0001 = block, 0000 = no decision yet.
- p2_choice, output, 4: same encoding as p1_choice.
- choices_valid, output, 1: high while the choice outputs hold a locked round result.
- round_active, output, 1: high in COLLECT.
- time_left, output, CNT_W: remaining collect cycles.
- p1_locked, output, 1: player 1 has committed this round.
- p2_locked, output, 1: player 2 has committed this round.
- p1_ammo, output, AMMO_W: player 1 ammo count.
- p2_ammo, output, AMMO_W: player 2 ammo count.

Behaviour:
- States: IDLE, COLLECT, PRESENT. All outputs are registered.
- Reset (asynchronous, immediate, in any state): state = IDLE; both choices = 0000; choices_valid = 0; round_active = 0; time_left = 0; both locked = 0; both ammo = INIT_AMMO.
- IDLE or PRESENT, start_round = 1 → COLLECT at the next edge:
  - time_left = ROUND_CYCLES-1.
  - Choices = 0000, choices_valid = 0, locked flags cleared, round_active = 1.
- start_round is ignored while in COLLECT.
- COLLECT, per player, each edge:
  - If not locked and any button bit is set, store the action and set locked.
  - If several bits are set in the same cycle, priority is shoot > block > reload.
  - Presses after a player has locked are ignored.
- COLLECT, time_left decrements by 1 each cycle and never wraps below 0.
- COLLECT exit condition at an edge: (p1_locked && p2_locked) || time_left == 0. At that edge the FSM enters PRESENT:
  - A press arriving on that same final edge from an unlocked player counts as that player's action.
  - Player with no action → 0010.
  - Shoot with ammo == 0 → 0010, ammo unchanged.
  - Shoot with ammo > 0 → 0100, ammo decremented.
  - Reload → 1000, ammo incremented, saturating at MAX_AMMO.
  - Block → 0001.
  - choices_valid = 1, round_active = 0.
- Early lock latency: the second player locks at edge N; PRESENT and valid choices appear at edge N+1.
- Timeout: with no locks, PRESENT is entered exactly ROUND_CYCLES edges after entering COLLECT.
- PRESENT holds choices, ammo and choices_valid stable indefinitely. The outcome calculator samples them on any later edge.
- Ammo changes only at the COLLECT→PRESENT edge.

Test Plan (overrides ROUND_CYCLES=8, CNT_W=4, MAX_AMMO=3, INIT_AMMO=1):
1. Assert rst_n=0 mid-stream, including mid-COLLECT with time_left=5 → outputs clear immediately without waiting for clk: choices 0000, valid 0, ammo 1/1, state IDLE. A stale start_round during COLLECT is ignored (time_left keeps counting).
2. start_round; p1_btn=010 at collect cycle 2; p2_btn=100 at cycle 3 → the edge after p2 locks gives p1_choice=0100, p2_choice=1000, choices_valid=1, p1_ammo=0, p2_ammo=2.
3. start_round; no presses → valid rises exactly 8 edges after COLLECT entry; both choices = 0010; ammo unchanged; round_active falls on the same edge.
4. Following test 2 (p1_ammo=0): p1 presses shoot, p2 presses block → p1_choice=0010, p2_choice=0001, p1_ammo stays 0.
5. p1_btn=111 in one cycle, then p1_btn=100 later → p1_choice=0100 (shoot priority; the later reload is ignored). Four consecutive reload rounds from ammo 1 → ammo saturates at 3, and each choice is 1000.
6. Only p2 presses, and does so on the final collect cycle (time_left=0) → that press is captured: p2_choice reflects it and p1_choice=0010. start_round in PRESENT → choices return to 0000 and valid=0 at the next edge.
